// File: rtl/hdr_parser_pkg.sv
// Shared definitions for the header metadata extractor: ethertypes, IP protocols,
// header byte offsets, the metadata record and the capture FSM state type.
package hdr_parser_pkg;

    localparam logic [15:0] ETH_ARP  = 16'h0806;
    localparam logic [15:0] ETH_IP   = 16'h0800;
    localparam logic [15:0] ETH_IP6  = 16'h86DD;
    localparam logic [15:0] ETH_VLAN = 16'h8100;

    localparam logic [7:0] IP_TCP = 8'd6;
    localparam logic [7:0] IP_UDP = 8'd17;

    // Offsets from the start of the frame
    localparam int OFF_DST_MAC    = 0;
    localparam int OFF_ETYPE      = 12;
    localparam int OFF_VLAN_TCI   = 14;
    localparam int OFF_ETYPE_VLAN = 16;
    localparam int L3_BASE        = 14;
    localparam int L3_BASE_VLAN   = 18;

    // Offsets relative to the start of the IPv4 header
    localparam int OFF_IP_VER_IHL = 0;
    localparam int OFF_IP_PROTO   = 9;
    localparam int OFF_IP_SRC     = 12;
    localparam int OFF_IP_DST     = 16;
    localparam int OFF_L4_SPORT   = 20;
    localparam int OFF_L4_DPORT   = 22;
    localparam int OFF_TCP_FLAGS  = 33;
    localparam int OFF_TCP_WIN    = 34;

    localparam int META_W = 142;

    typedef struct packed {
        logic [7:0]   flags;    // {arp,ip,ip6,bcast,tcp,udp,trunc,vlan}
        logic [103:0] flow_id;  // {src_ip,dst_ip,src_port,dst_port,proto}
        logic [17:0]  tcp;      // {window,syn,fin}
        logic [11:0]  vlan_id;
    } meta_t;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_EMIT    = 2'd1,
        ST_SKIP    = 2'd2
    } state_t;

endpackage

// File: rtl/hdr_meta_extractor_if.sv
// Bundle for the passive AXIS tap (observed stream) and the metadata queue output.
// The slave modport is the extractor's view; master is the environment's view.
interface hdr_meta_extractor_if #(
    parameter int DW = 512
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          meta_valid;
    logic          meta_ready;
    logic [7:0]    meta_flags;
    logic [103:0]  meta_flow_id;
    logic [17:0]   meta_tcp;
    logic [11:0]   meta_vlan_id;
    logic [31:0]   drop_cnt;

    modport master (
        output tdata, tvalid, tlast, meta_ready,
        input  meta_valid, meta_flags, meta_flow_id, meta_tcp, meta_vlan_id, drop_cnt
    );

    modport slave (
        input  tdata, tvalid, tlast, meta_ready,
        output meta_valid, meta_flags, meta_flow_id, meta_tcp, meta_vlan_id, drop_cnt
    );
endinterface

// File: rtl/fallthrough_small_fifo.sv
// Small fall-through FIFO used as the metadata queue. The head becomes visible one
// cycle after it is written, and a push into a full queue is taken when a pop coincides.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 142,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din_i,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam int CW    = MAX_DEPTH_BITS + 1;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]             count_q, count_d;
    logic                      valid_q, valid_d;
    logic                      push, pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign pop     = rd_en_i & valid_q;
    assign push    = wr_en_i & (~full_o | pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign empty_o = ~valid_q;

    // Visibility ignores this cycle's push, giving the extra cycle of head latency
    always_comb begin
        count_d = count_q + CW'(push) - CW'(pop);
        valid_d = ((count_q - CW'(pop)) != '0);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + MAX_DEPTH_BITS'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + MAX_DEPTH_BITS'(1);
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/hdr_meta_extractor.sv
// Passive AXIS tap that captures the first HDR_BYTES of each packet and queues decoded
// L2/L3/L4 metadata. Define VLAN_PARSE_EN to decode 802.1Q-tagged frames.
module hdr_meta_extractor
    import hdr_parser_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 512,
    parameter int FIFO_DEPTH_BITS     = 2,
    parameter int HDR_BYTES           = 64
) (
    input logic                 clk,
    input logic                 reset,
    hdr_meta_extractor_if.slave tap
);
    localparam int DW        = C_S_AXIS_DATA_WIDTH;
    localparam int HDR_W     = HDR_BYTES * 8;
    localparam int HDR_BEATS = HDR_W / DW;
    localparam int IDX_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_BEATS - 1);

    function automatic logic [7:0] hb(input logic [HDR_W-1:0] h, input int i);
        if (i < HDR_BYTES) return h[i*8 +: 8];
        return 8'h00;
    endfunction

    function automatic logic [15:0] hw16(input logic [HDR_W-1:0] h, input int i);
        return {hb(h, i), hb(h, i + 1)};
    endfunction

    function automatic logic [31:0] hw32(input logic [HDR_W-1:0] h, input int i);
        return {hw16(h, i), hw16(h, i + 2)};
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t           state_q;
    logic [IDX_W-1:0] beat_idx_q;
    logic [HDR_W-1:0] cap_q, dec_q, merged;
    logic             trunc_q, last_seen_q;
    logic [31:0]      drop_cnt_q;
    logic             capture, complete;

    // A beat in EMIT belongs to the next packet only if the previous one already ended
    assign capture  = tap.tvalid & ((state_q == ST_CAPTURE) | ((state_q == ST_EMIT) & last_seen_q));
    assign complete = capture & ((beat_idx_q == LAST_IDX) | tap.tlast);

    always_comb begin
        merged = cap_q;
        merged[int'(beat_idx_q)*DW +: DW] = tap.tdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CAPTURE;
            beat_idx_q  <= '0;
            cap_q       <= '0;
            dec_q       <= '0;
            trunc_q     <= 1'b0;
            last_seen_q <= 1'b0;
        end else if (capture) begin
            if (complete) begin
                dec_q       <= merged;
                cap_q       <= '0;
                beat_idx_q  <= '0;
                trunc_q     <= tap.tlast & (beat_idx_q != LAST_IDX);
                last_seen_q <= tap.tlast;
                state_q     <= ST_EMIT;
            end else begin
                cap_q      <= merged;
                beat_idx_q <= beat_idx_q + IDX_W'(1);
                state_q    <= ST_CAPTURE;
            end
        end else begin
            case (state_q)
                ST_EMIT: begin
                    if (last_seen_q || (tap.tvalid && tap.tlast)) state_q <= ST_CAPTURE;
                    else                                          state_q <= ST_SKIP;
                end
                ST_SKIP: begin
                    if (tap.tvalid && tap.tlast) state_q <= ST_CAPTURE;
                end
                default: state_q <= ST_CAPTURE;
            endcase
        end
    end

    logic [15:0] etype_outer, etype, vid16;
    logic [7:0]  dst0, ver_ihl, proto, tcp_flg;
    logic        vlan_tag, is_arp, is_ip, is_ip6, is_tcp, is_udp, l4_ok;
    int          l3;
    meta_t       meta_d;

    always_comb begin
        etype_outer = hw16(dec_q, OFF_ETYPE);
        etype       = etype_outer;
        vlan_tag    = 1'b0;
        vid16       = '0;
        l3          = L3_BASE;
`ifdef VLAN_PARSE_EN
        if (etype_outer == ETH_VLAN) begin
            vlan_tag = 1'b1;
            vid16    = hw16(dec_q, OFF_VLAN_TCI);
            etype    = hw16(dec_q, OFF_ETYPE_VLAN);
            l3       = L3_BASE_VLAN;
        end
`endif
        dst0    = hb(dec_q, OFF_DST_MAC);
        ver_ihl = hb(dec_q, l3 + OFF_IP_VER_IHL);
        proto   = hb(dec_q, l3 + OFF_IP_PROTO);
        tcp_flg = hb(dec_q, l3 + OFF_TCP_FLAGS);
        is_arp  = (etype == ETH_ARP);
        is_ip   = (etype == ETH_IP);
        is_ip6  = (etype == ETH_IP6);
        is_tcp  = is_ip & (proto == IP_TCP);
        is_udp  = is_ip & (proto == IP_UDP);
        l4_ok   = is_ip & (ver_ihl[3:0] == 4'd5);

        meta_d         = '0;
        meta_d.flags   = {is_arp, is_ip, is_ip6, dst0[0], is_tcp, is_udp, trunc_q, vlan_tag};
        meta_d.vlan_id = vid16[11:0];
        if (is_ip) begin
            meta_d.flow_id = {hw32(dec_q, l3 + OFF_IP_SRC), hw32(dec_q, l3 + OFF_IP_DST),
                              32'h0, proto};
            if (l4_ok) meta_d.flow_id[39:8] = {hw16(dec_q, l3 + OFF_L4_SPORT),
                                               hw16(dec_q, l3 + OFF_L4_DPORT)};
        end
        if (is_tcp && l4_ok)
            meta_d.tcp = {hw16(dec_q, l3 + OFF_TCP_WIN), tcp_flg[1], tcp_flg[0]};
    end

    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{dst0[7:1], ver_ihl[7:4], tcp_flg[7:2], vid16[15:12]};

    logic  push, pop, q_full, q_empty, wr_en, drop;
    logic [META_W-1:0] q_dout;
    meta_t head;

    assign push  = (state_q == ST_EMIT);
    assign pop   = tap.meta_valid & tap.meta_ready;
    assign wr_en = push & (~q_full | pop);
    assign drop  = push & q_full & ~pop;

    fallthrough_small_fifo #(
        .WIDTH          (META_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_meta_q (
        .clk     (clk),
        .reset   (reset),
        .din_i   (meta_d),
        .wr_en_i (wr_en),
        .rd_en_i (pop),
        .dout_o  (q_dout),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset)     drop_cnt_q <= '0;
        else if (drop) drop_cnt_q <= sat_inc32(drop_cnt_q);
    end

    assign head             = meta_t'(q_dout);
    assign tap.meta_valid   = ~q_empty;
    assign tap.meta_flags   = head.flags;
    assign tap.meta_flow_id = head.flow_id;
    assign tap.meta_tcp     = head.tcp;
    assign tap.meta_vlan_id = head.vlan_id;
    assign tap.drop_cnt     = drop_cnt_q;
endmodule

// File: tb/tb_hdr_meta_extractor.sv
// Scoreboard bench for hdr_meta_extractor: a 512-bit and a 256-bit instance driven with
// directed packets; per-instance monitors pop expected records on every handshake.
module tb_hdr_meta_extractor;
    import hdr_parser_pkg::*;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    meta_t exp_a[$], exp_b[$];
    int    tag_a[$], tag_b[$];
    meta_t act_a, act_b, e_a, e_b;
    int    id_a, id_b;

    hdr_meta_extractor_if #(.DW(512)) ifa();
    hdr_meta_extractor_if #(.DW(256)) ifb();

    hdr_meta_extractor #(.C_S_AXIS_DATA_WIDTH(512), .FIFO_DEPTH_BITS(2), .HDR_BYTES(64)) dut_a (
        .clk(clk), .reset(rst_a), .tap(ifa.slave));
    hdr_meta_extractor #(.C_S_AXIS_DATA_WIDTH(256), .FIFO_DEPTH_BITS(2), .HDR_BYTES(64)) dut_b (
        .clk(clk), .reset(rst_b), .tap(ifb.slave));

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_hdr(input logic [7:0] mac0, input logic vlan,
        input logic [15:0] vid, input logic [15:0] etype, input logic [7:0] verihl,
        input logic [7:0] proto, input logic [31:0] sip, input logic [31:0] dip,
        input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] tflg,
        input logic [15:0] win);
        logic [7:0] b [64];
        logic [511:0] h;
        int L;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        b[0] = mac0;
        for (int i = 1; i < 6; i++)  b[i] = 8'h22;
        for (int i = 6; i < 12; i++) b[i] = 8'h33;
        L = vlan ? 18 : 14;
        if (vlan) begin
            b[12] = 8'h81; b[13] = 8'h00; b[14] = vid[15:8]; b[15] = vid[7:0];
        end
        b[L-2] = etype[15:8]; b[L-1] = etype[7:0];
        b[L]   = verihl;
        b[L+9] = proto;
        for (int i = 0; i < 4; i++) begin
            b[L+12+i] = sip[31-8*i -: 8];
            b[L+16+i] = dip[31-8*i -: 8];
        end
        b[L+20] = sp[15:8]; b[L+21] = sp[7:0];
        b[L+22] = dp[15:8]; b[L+23] = dp[7:0];
        b[L+33] = tflg;
        b[L+34] = win[15:8]; b[L+35] = win[7:0];
        for (int i = 0; i < 64; i++) h[i*8 +: 8] = b[i];
        return h;
    endfunction

    function automatic meta_t mm(input logic [7:0] f, input logic [103:0] fl,
                                 input logic [17:0] t, input logic [11:0] v);
        return {f, fl, t, v};
    endfunction

    always @(negedge clk) begin
        if (rst_a !== 1'b1 && ifa.meta_valid === 1'b1 && ifa.meta_ready === 1'b1) begin
            act_a = {ifa.meta_flags, ifa.meta_flow_id, ifa.meta_tcp, ifa.meta_vlan_id};
            if (exp_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_a got=%h want=none", act_a);
            end else begin
                e_a = exp_a.pop_front(); id_a = tag_a.pop_front();
                chk($sformatf("entry_a%0d", id_a), 160'(act_a), 160'(e_a));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_b !== 1'b1 && ifb.meta_valid === 1'b1 && ifb.meta_ready === 1'b1) begin
            act_b = {ifb.meta_flags, ifb.meta_flow_id, ifb.meta_tcp, ifb.meta_vlan_id};
            if (exp_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_b got=%h want=none", act_b);
            end else begin
                e_b = exp_b.pop_front(); id_b = tag_b.pop_front();
                chk($sformatf("entry_b%0d", id_b), 160'(act_b), 160'(e_b));
            end
        end
    end

    task automatic send_a(input logic [511:0] h);
        @(posedge clk); #1;
        ifa.tdata = h; ifa.tvalid = 1'b1; ifa.tlast = 1'b1;
    endtask

    task automatic idle_a();
        @(posedge clk); #1;
        ifa.tvalid = 1'b0; ifa.tlast = 1'b0;
    endtask

    task automatic send_b(input logic [511:0] h, input int n, input logic [255:0] extra);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            ifb.tdata  = (i < 2) ? h[i*256 +: 256] : extra;
            ifb.tvalid = 1'b1;
            ifb.tlast  = (i == n - 1);
        end
    endtask

    task automatic idle_b();
        @(posedge clk); #1;
        ifb.tvalid = 1'b0; ifb.tlast = 1'b0;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 100 && exp_a.size() != 0; i++) @(posedge clk);
        #1 chk("drain_a", 160'(exp_a.size()), 160'd0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 100 && exp_b.size() != 0; i++) @(posedge clk);
        #1 chk("drain_b", 160'(exp_b.size()), 160'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    logic [511:0] h1, h2, h4, h5;
    logic [255:0] payload;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.tdata = '0; ifa.tvalid = 1'b0; ifa.tlast = 1'b0; ifa.meta_ready = 1'b1;
        ifb.tdata = '0; ifb.tvalid = 1'b0; ifb.tlast = 1'b0; ifb.meta_ready = 1'b1;
        payload = {8{32'hdeadbeef}};
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        chk("rst_valid_a", 160'(ifa.meta_valid), 160'd0);
        chk("rst_drop_a",  160'(ifa.drop_cnt),   160'd0);
        chk("rst_valid_b", 160'(ifb.meta_valid), 160'd0);
        chk("rst_drop_b",  160'(ifb.drop_cnt),   160'd0);

        // 512b single-beat IPv4/TCP SYN, with head latency
        h1 = mk_hdr(8'h00, 1'b0, 16'h0, ETH_IP, 8'h45, IP_TCP, 32'h0a000001, 32'h0a000002,
                    16'd1234, 16'd80, 8'h02, 16'h2000);
        exp_a.push_back(mm(8'h48, 104'h0a000001_0a000002_04d2_0050_06, 18'h08002, 12'h0));
        tag_a.push_back(1);
        send_a(h1);
        idle_a();
        @(posedge clk); #1 chk("lat_n1_valid", 160'(ifa.meta_valid), 160'd0);
        @(posedge clk); #1 chk("lat_n2_valid", 160'(ifa.meta_valid), 160'd1);
        drain_a();

        // 256b three-beat broadcast UDP; header spans beats 0-1
        h2 = mk_hdr(8'hff, 1'b0, 16'h0, ETH_IP, 8'h45, IP_UDP, 32'h0a000003, 32'h0a000004,
                    16'd5000, 16'd53, 8'h00, 16'h0000);
        exp_b.push_back(mm(8'h54, 104'h0a000003_0a000004_1388_0035_11, 18'h0, 12'h0));
        tag_b.push_back(2);
        send_b(h2, 3, payload);
        idle_b();

        // 256b single-beat TCP: truncated, bytes 32+ read as zero
        exp_b.push_back(mm(8'h4A, 104'h0a000001_0a000000_0000_0000_06, 18'h0, 12'h0));
        tag_b.push_back(3);
        send_b(h1, 1, payload);
        idle_b();
        drain_b();

        // Queue overflow: six back-to-back packets with the consumer stalled
        ifa.meta_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            h4 = mk_hdr(8'h00, 1'b0, 16'h0, ETH_IP, 8'h45, IP_TCP, 32'h0a000001, 32'h0a000002,
                        16'd1000 + 16'(k), 16'd80, 8'h01, 16'h0100);
            if (k < 4) begin
                exp_a.push_back(mm(8'h48, {32'h0a000001, 32'h0a000002, 16'h03e8 + 16'(k),
                                           16'h0050, 8'h06}, 18'h00401, 12'h0));
                tag_a.push_back(40 + k);
            end
            send_a(h4);
        end
        idle_a();
        repeat (5) @(posedge clk);
        #1;
        chk("ovf_drop_cnt", 160'(ifa.drop_cnt),   160'd2);
        chk("ovf_valid",    160'(ifa.meta_valid), 160'd1);
        ifa.meta_ready = 1'b1;
        drain_a();

        // VLAN-tagged IPv4/UDP, VID 100
        h5 = mk_hdr(8'h00, 1'b1, 16'd100, ETH_IP, 8'h45, IP_UDP, 32'hc0a80101, 32'hc0a80102,
                    16'd4000, 16'd8000, 8'h00, 16'h0000);
`ifdef VLAN_PARSE_EN
        exp_a.push_back(mm(8'h45, 104'hc0a80101_c0a80102_0fa0_1f40_11, 18'h0, 12'd100));
`else
        exp_a.push_back(mm(8'h00, 104'h0, 18'h0, 12'h0));
`endif
        tag_a.push_back(5);
        send_a(h5);
        idle_a();
        drain_a();

        // Reset in the middle of a 3-beat packet, then a clean packet
        @(posedge clk); #1;
        ifb.tdata = h2[255:0]; ifb.tvalid = 1'b1; ifb.tlast = 1'b0;
        @(posedge clk); #1;
        ifb.tvalid = 1'b0; rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        exp_b.push_back(mm(8'h54, 104'h0a000003_0a000004_1388_0035_11, 18'h0, 12'h0));
        tag_b.push_back(6);
        send_b(h2, 3, payload);
        idle_b();
        drain_b();
        repeat (10) @(posedge clk);
        #1;
        chk("rst_mid_drop_b",  160'(ifb.drop_cnt),   160'd0);
        chk("rst_mid_valid_b", 160'(ifb.meta_valid), 160'd0);
        chk("final_drop_a",    160'(ifa.drop_cnt),   160'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
